// File: rtl/hs_npu_mac_pe.sv
// Systolic MAC processing element for the hs_npu array: valid-qualified datapath,
// double-buffered weights chained south, optional saturating accumulate with sticky flag.
module hs_npu_mac_pe #(
  parameter int unsigned A_W    = 16,
  parameter int unsigned W_W    = 16,
  parameter int unsigned ACC_W  = 32,
  parameter bit          SAT_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a_valid_in,
  input  logic signed [A_W-1:0]   a_in,
  input  logic signed [ACC_W-1:0] sum_in,
  input  logic                    w_load_in,
  input  logic signed [W_W-1:0]   w_in,
  input  logic                    w_commit_in,
  input  logic                    sat_clr_in,
  output logic                    a_valid_out,
  output logic signed [A_W-1:0]   a_out,
  output logic                    w_load_out,
  output logic signed [W_W-1:0]   w_out,
  output logic                    w_commit_out,
  output logic                    result_valid,
  output logic signed [ACC_W-1:0] result,
  output logic                    sat_flag
);

  localparam int unsigned P_W = A_W + W_W;
  localparam int unsigned S_W = ACC_W + 1;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  if (ACC_W < P_W) begin : g_width_check
    $error("hs_npu_mac_pe: ACC_W must be >= A_W + W_W");
  end

  logic signed [W_W-1:0]   w_shadow;
  logic signed [W_W-1:0]   w_active;
  logic signed [P_W-1:0]   a_ext;
  logic signed [P_W-1:0]   w_ext;
  logic signed [P_W-1:0]   product;
  logic signed [S_W-1:0]   prod_ext;
  logic signed [S_W-1:0]   sum_ext;
  logic signed [S_W-1:0]   sum_exact;
  logic                    overflow;
  logic signed [ACC_W-1:0] sum_reduced;

  assign w_out = w_shadow;

  // One guard bit above ACC_W makes the exact sum representable; overflow is a
  // disagreement between the guard bit and the ACC_W sign bit.
  always_comb begin
    a_ext       = P_W'(a_in);
    w_ext       = P_W'(w_active);
    product     = a_ext * w_ext;
    prod_ext    = S_W'(product);
    sum_ext     = S_W'(sum_in);
    sum_exact   = prod_ext + sum_ext;
    overflow    = sum_exact[S_W-1] ^ sum_exact[ACC_W-1];
    sum_reduced = sum_exact[ACC_W-1:0];
    if (SAT_EN && overflow) begin
      sum_reduced = sum_exact[S_W-1] ? ACC_MIN : ACC_MAX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out       <= '0;
      a_valid_out <= 1'b0;
    end else begin
      a_out       <= a_in;
      a_valid_out <= a_valid_in;
    end
  end

  // Commit reads the shadow before this edge, so a same-edge load is not seen by active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_shadow     <= '0;
      w_active     <= '0;
      w_load_out   <= 1'b0;
      w_commit_out <= 1'b0;
    end else begin
      w_load_out   <= w_load_in;
      w_commit_out <= w_commit_in;
      if (w_load_in) begin
        w_shadow <= w_in;
      end
      if (w_commit_in) begin
        w_active <= w_shadow;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= a_valid_in;
      if (a_valid_in) begin
        result <= sum_reduced;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
    end else if (a_valid_in && overflow) begin
      sat_flag <= 1'b1;
    end else if (sat_clr_in) begin
      sat_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hs_npu_mac_pe.sv
// Self-checking bench for hs_npu_mac_pe: saturating and wrapping instances driven in
// lockstep and compared every cycle against an integer-arithmetic reference model.
module tb_hs_npu_mac_pe;

  localparam int A_W   = 16;
  localparam int W_W   = 16;
  localparam int ACC_W = 32;
  localparam longint ACC_MAX = 64'sd2147483647;
  localparam longint ACC_MIN = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                    a_valid_in = 1'b0;
  logic signed [A_W-1:0]   a_in = '0;
  logic signed [ACC_W-1:0] sum_in = '0;
  logic                    w_load_in = 1'b0;
  logic signed [W_W-1:0]   w_in = '0;
  logic                    w_commit_in = 1'b0;
  logic                    sat_clr_in = 1'b0;

  logic                    s_a_valid_out, w_a_valid_out;
  logic signed [A_W-1:0]   s_a_out, w_a_out;
  logic                    s_w_load_out, w_w_load_out;
  logic signed [W_W-1:0]   s_w_out, w_w_out;
  logic                    s_w_commit_out, w_w_commit_out;
  logic                    s_result_valid, w_result_valid;
  logic signed [ACC_W-1:0] s_result, w_result;
  logic                    s_sat_flag, w_sat_flag;

  hs_npu_mac_pe #(.A_W(A_W), .W_W(W_W), .ACC_W(ACC_W), .SAT_EN(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .a_valid_in(a_valid_in), .a_in(a_in), .sum_in(sum_in),
    .w_load_in(w_load_in), .w_in(w_in), .w_commit_in(w_commit_in), .sat_clr_in(sat_clr_in),
    .a_valid_out(s_a_valid_out), .a_out(s_a_out), .w_load_out(s_w_load_out), .w_out(s_w_out),
    .w_commit_out(s_w_commit_out), .result_valid(s_result_valid), .result(s_result),
    .sat_flag(s_sat_flag)
  );

  hs_npu_mac_pe #(.A_W(A_W), .W_W(W_W), .ACC_W(ACC_W), .SAT_EN(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .a_valid_in(a_valid_in), .a_in(a_in), .sum_in(sum_in),
    .w_load_in(w_load_in), .w_in(w_in), .w_commit_in(w_commit_in), .sat_clr_in(sat_clr_in),
    .a_valid_out(w_a_valid_out), .a_out(w_a_out), .w_load_out(w_w_load_out), .w_out(w_w_out),
    .w_commit_out(w_w_commit_out), .result_valid(w_result_valid), .result(w_result),
    .sat_flag(w_sat_flag)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model state (shared pipeline registers, per-instance result/flag)
  logic signed [A_W-1:0]   m_a_out;
  logic                    m_a_valid_out;
  logic signed [W_W-1:0]   m_shadow, m_active;
  logic                    m_w_load_out, m_w_commit_out, m_rv;
  logic signed [ACC_W-1:0] m_res_s, m_res_w;
  logic                    m_flag_s, m_flag_w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_a_out = '0; m_a_valid_out = 1'b0; m_shadow = '0; m_active = '0;
    m_w_load_out = 1'b0; m_w_commit_out = 1'b0; m_rv = 1'b0;
    m_res_s = '0; m_res_w = '0; m_flag_s = 1'b0; m_flag_w = 1'b0;
  endtask

  task automatic model_step();
    longint exact;
    bit     over;
    if (!rst_n) begin
      model_reset();
      return;
    end
    exact = longint'(a_in) * longint'(m_active) + longint'(sum_in);
    over  = a_valid_in && (exact > ACC_MAX || exact < ACC_MIN);
    if (a_valid_in) begin
      if (exact > ACC_MAX)      m_res_s = 32'(ACC_MAX);
      else if (exact < ACC_MIN) m_res_s = 32'(ACC_MIN);
      else                      m_res_s = 32'(exact);
      m_res_w = 32'(exact);
    end
    if (over) begin
      m_flag_s = 1'b1; m_flag_w = 1'b1;
    end else if (sat_clr_in) begin
      m_flag_s = 1'b0; m_flag_w = 1'b0;
    end
    m_rv = a_valid_in;
    m_a_out = a_in;
    m_a_valid_out = a_valid_in;
    m_w_load_out = w_load_in;
    m_w_commit_out = w_commit_in;
    if (w_commit_in) m_active = m_shadow;
    if (w_load_in)   m_shadow = w_in;
  endtask

  task automatic check_all();
    chk("s_a_out", 32'(s_a_out), 32'(m_a_out));
    chk("s_a_valid_out", 32'(s_a_valid_out), 32'(m_a_valid_out));
    chk("s_w_out", 32'(s_w_out), 32'(m_shadow));
    chk("s_w_load_out", 32'(s_w_load_out), 32'(m_w_load_out));
    chk("s_w_commit_out", 32'(s_w_commit_out), 32'(m_w_commit_out));
    chk("s_result_valid", 32'(s_result_valid), 32'(m_rv));
    chk("s_result", s_result, m_res_s);
    chk("s_sat_flag", 32'(s_sat_flag), 32'(m_flag_s));
    chk("w_a_out", 32'(w_a_out), 32'(m_a_out));
    chk("w_w_out", 32'(w_w_out), 32'(m_shadow));
    chk("w_w_commit_out", 32'(w_w_commit_out), 32'(m_w_commit_out));
    chk("w_result_valid", 32'(w_result_valid), 32'(m_rv));
    chk("w_result", w_result, m_res_w);
    chk("w_sat_flag", 32'(w_sat_flag), 32'(m_flag_w));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic clear_in();
    a_valid_in = 1'b0; a_in = '0; sum_in = '0;
    w_load_in = 1'b0; w_in = '0; w_commit_in = 1'b0; sat_clr_in = 1'b0;
  endtask

  task automatic rand_in();
    a_valid_in  = 1'($urandom_range(0, 1));
    a_in        = 16'($urandom);
    sum_in      = 32'($urandom);
    w_load_in   = ($urandom_range(0, 3) == 0);
    w_in        = 16'($urandom);
    w_commit_in = ($urandom_range(0, 4) == 0);
    sat_clr_in  = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    model_reset();
    // Reset held with random inputs: everything stays zero
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_in();
      step();
      chk("rst_result", s_result, 32'd0);
      chk("rst_w_out", 32'(s_w_out), 32'd0);
    end
    clear_in();
    rst_n = 1'b1;

    a_valid_in = 1'b1; a_in = 16'sd5; sum_in = 32'sd7;
    step();
    chk("post_rst_result", s_result, 32'd7);
    chk("post_rst_rv", 32'(s_result_valid), 32'd1);

    clear_in(); w_load_in = 1'b1; w_in = 16'sd3;
    step();
    chk("load3_w_out", 32'(s_w_out), 32'd3);
    clear_in(); w_commit_in = 1'b1;
    step();
    chk("commit_out", 32'(s_w_commit_out), 32'd1);
    clear_in(); a_valid_in = 1'b1; a_in = -16'sd4; sum_in = 32'sd100;
    step();
    chk("compute_88", s_result, 32'd88);

    // Same-edge load, commit and compute
    clear_in(); w_load_in = 1'b1; w_in = 16'sd9; w_commit_in = 1'b1;
    a_valid_in = 1'b1; a_in = 16'sd2; sum_in = 32'sd0;
    step();
    chk("dbuf_result_6", s_result, 32'd6);
    chk("dbuf_shadow_9", 32'(s_w_out), 32'd9);
    clear_in(); a_valid_in = 1'b1; a_in = 16'sd2;
    step();
    chk("dbuf_active_3", s_result, 32'd6);
    clear_in(); w_commit_in = 1'b1;
    step();
    clear_in(); a_valid_in = 1'b1; a_in = 16'sd2;
    step();
    chk("dbuf_result_18", s_result, 32'd18);

    // Saturation vs wrap
    clear_in(); w_load_in = 1'b1; w_in = 16'sd32767;
    step();
    clear_in(); w_commit_in = 1'b1;
    step();
    clear_in(); a_valid_in = 1'b1; a_in = 16'sd32767; sum_in = 32'sd2147483647;
    step();
    chk("sat_result", s_result, 32'h7fffffff);
    chk("sat_flag_set", 32'(s_sat_flag), 32'd1);
    chk("wrap_result", w_result, 32'hbfff0000);
    chk("wrap_flag_set", 32'(w_sat_flag), 32'd1);
    clear_in(); sat_clr_in = 1'b1;
    step();
    chk("sat_flag_clr", 32'(s_sat_flag), 32'd0);
    chk("sat_hold_result", s_result, 32'h7fffffff);
    clear_in(); sat_clr_in = 1'b1; a_valid_in = 1'b1; a_in = 16'sd32767; sum_in = 32'sd2147483647;
    step();
    chk("set_beats_clr", 32'(s_sat_flag), 32'd1);
    clear_in(); sat_clr_in = 1'b1;
    step();

    // Valid gating with active = 32767
    clear_in(); a_valid_in = 1'b1; a_in = 16'sd10; sum_in = 32'sd1;
    step();
    chk("gate_v1", s_result, 32'd327671);
    clear_in(); a_in = 16'sd20; sum_in = 32'sd1;
    step();
    chk("gate_hold1", s_result, 32'd327671);
    chk("gate_rv0", 32'(s_result_valid), 32'd0);
    chk("gate_a_out", 32'(s_a_out), 32'd20);
    clear_in(); a_in = 16'sd30; sum_in = 32'sd1;
    step();
    chk("gate_hold2", s_result, 32'd327671);
    clear_in(); a_valid_in = 1'b1; a_in = 16'sd40; sum_in = 32'sd1;
    step();
    chk("gate_v2", s_result, 32'd1310681);

    // Asynchronous reset in the middle of a load burst
    clear_in(); w_load_in = 1'b1; w_in = 16'sd123;
    step();
    w_in = 16'sd456;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_w_out", 32'(s_w_out), 32'd0);
    chk("async_result", s_result, 32'd0);
    check_all();
    step();
    clear_in();
    rst_n = 1'b1;
    a_valid_in = 1'b1; a_in = 16'sd3; sum_in = -32'sd5;
    step();
    chk("post_async_sum_only", s_result, 32'hfffffffb);
    clear_in(); w_load_in = 1'b1; w_in = 16'sd7;
    step();
    clear_in(); w_commit_in = 1'b1;
    step();
    clear_in(); a_valid_in = 1'b1; a_in = 16'sd3; sum_in = -32'sd5;
    step();
    chk("reload_result", s_result, 32'd16);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rand_in();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
